fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake. Holds each word in an instruction register and presents it as `ir_data` with a valid/ready handshake. Applies sequential or branch next-PC selection when the control unit consumes an instruction.

## Interface
- `PC_WIDTH`, default 8: program counter / instruction address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_addr` output PC_WIDTH: fetch address; equals `pc` while `imem_req`=1.
- `imem_req` output 1: fetch request; held high until acked.
- `imem_ack` input 1: memory response; `imem_rdata` valid in the same cycle.
- `imem_rdata` input 16: instruction word from memory.
- `ir_data` output 16: instruction register, feeds the control unit.
- `ir_valid` output 1: `ir_data` holds an unconsumed instruction.
- `ir_ready` input 1: control unit accepts `ir_data` this cycle.
- `branch_en` input 1: redirect; sampled only on the `ir_valid & ir_ready` cycle.
- `branch_target` input PC_WIDTH: next PC when `branch_en`=1.
- `pc` output PC_WIDTH: address of the instruction being fetched or held.
- `halt` output 1: fetch stopped by a HALT instruction.

## Operation
- FSM states are IDLE (reset), FETCH, HOLD and HALTED.
- IDLE -> FETCH unconditionally after one cycle.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both stable until `imem_ack`.
  - On `imem_ack`, capture `imem_rdata` into `ir_data`.
  - If `imem_rdata[15:12]`=4'b1111 and `FETCH_HALT_EN` is defined, go to HALTED.
  - Otherwise go to HOLD.
- HOLD: `ir_valid`=1 and `imem_req`=0. `ir_data` and `pc` are stable while `ir_ready`=0.
  - On `ir_ready`=1: `pc` <= `branch_target` if `branch_en`, else `pc`+1. Then go to FETCH.
- HALTED: `halt`=1, `imem_req`=0, `ir_valid`=0. Only `rst` exits this state.
- `pc`+1 is modulo 2^PC_WIDTH: all-ones wraps to 0 with no flag.
- `branch_en` outside the HOLD-accept cycle is ignored.
- `imem_ack` outside FETCH is ignored and does not change `ir_data`.
- Reset values: `pc`=RESET_PC, `ir_data`=16'h0000, and `imem_req`, `ir_valid` and `halt` all 0. State after reset is IDLE.
- Reset mid-operation: in any state, `rst` overrides everything.
  - An outstanding request is dropped.
  - An `imem_ack` arriving in a reset cycle is ignored.
  - A held instruction is discarded.

## Timing
- All outputs are registered.
- After `rst` falls: IDLE for one cycle, then `imem_req`=1 on the 2nd cycle.
- Fetch latency: an ack in FETCH cycle N gives `ir_valid`=1 in cycle N+1.
- Accept in HOLD cycle M gives `imem_req`=1 with the new `pc` in cycle M+1.
- Peak throughput is one instruction per 2 cycles (ack in the same cycle as req, `ir_ready` held high).
- Handshake rules:
  - `imem_req` never drops before `imem_ack`.
  - `ir_valid` never drops before `ir_ready`.
  - At most one request is outstanding.

## Configuration
- `FETCH_HALT_EN` defined: opcode 4'b1111 enters HALTED. The HALT word is loaded into `ir_data` but never presented (`ir_valid` stays 0), and `halt` rises the cycle after the ack.
- `FETCH_HALT_EN` undefined: opcode 4'b1111 is an ordinary instruction presented via HOLD, and `halt` is tied to 0.

## Test plan
- Reset then sequential fetch, zero-wait memory, `ir_ready`=1: `imem_addr` sequence 0,1,2 on cycles 2,4,6 after reset release. `ir_data` equals the memory words; `ir_valid` pulses one cycle each.
- Wait-state memory, ack 3 cycles after req, `ir_ready`=0 for 4 cycles: `imem_req` and `imem_addr` are stable until ack. `ir_data`=16'h0123 is held with `ir_valid`=1 until accept; no new req during HOLD.
- Branch at PC=5 with `branch_en`=1, `branch_target`=8'h20: next `imem_addr`=8'h20. A separate `branch_en` pulse during FETCH has no effect.
- PC wrap with RESET_PC=8'hFE, sequential: addresses FE, FF, 00, 01.
- HALT, compiled with `FETCH_HALT_EN`, word 16'hF000 at address 3: after instructions 0–2, `halt`=1, `ir_valid` and `imem_req` stay 0 for 20 cycles, and `pc`=3. Without the macro, 16'hF000 is presented with `ir_valid`=1 and fetch continues at 4.
- Reset asserted while `imem_req`=1 at PC=7, with ack in the same cycle: `ir_data` stays 16'h0000 and `pc`=RESET_PC. Fetch restarts at RESET_PC on the 2nd cycle after release.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the
// instruction-register valid/ready port toward the control unit.
//   master: the fetch unit (drives imem_addr/imem_req, ir_data/ir_valid,
//           pc, halt; samples imem_ack/imem_rdata, ir_ready,
//           branch_en/branch_target)
//   slave : memory + control unit side (the mirror image)
interface fetch_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_req;
  logic                imem_ack;
  logic [15:0]         imem_rdata;
  logic [15:0]         ir_data;
  logic                ir_valid;
  logic                ir_ready;
  logic                branch_en;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] pc;
  logic                halt;

  modport master (
    output imem_addr, imem_req,
    input  imem_ack, imem_rdata,
    output ir_data, ir_valid,
    input  ir_ready, branch_en, branch_target,
    output pc, halt
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_ack, imem_rdata,
    input  ir_data, ir_valid,
    output ir_ready, branch_en, branch_target,
    input  pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the program counter, fetches 16-bit words
// over a req/ack handshake, holds each word in the instruction register and
// presents it with valid/ready. On accept, PC advances by one (wrapping) or
// jumps to branch_target.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_if.master (imem_*, ir_*, branch_*, pc, halt)
// Optional feature macro: FETCH_HALT_EN -- opcode 4'b1111 stops fetching
// (HALTED state, halt=1). Without it, halt is tied low and 4'b1111 is an
// ordinary instruction.
module fetch_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_ir;
  logic                r_req;
  logic                r_valid;
`ifdef FETCH_HALT_EN
  logic                r_halt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      r_halt  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          // Request and address stay put until the ack arrives.
          if (bus.imem_ack) begin
            r_ir  <= bus.imem_rdata;
            r_req <= 1'b0;
`ifdef FETCH_HALT_EN
            if (bus.imem_rdata[15:12] == 4'b1111) begin
              // HALT word is latched but never presented.
              r_state <= S_HALTED;
              r_halt  <= 1'b1;
            end else begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
            end
`else
            r_state <= S_HOLD;
            r_valid <= 1'b1;
`endif
          end
        end
        S_HOLD: begin
          // Branch inputs only matter on the accept cycle.
          if (bus.ir_ready) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
            r_pc    <= bus.branch_en ? bus.branch_target : r_pc + PC_WIDTH'(1);
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.imem_req  = r_req;
  assign bus.ir_data   = r_ir;
  assign bus.ir_valid  = r_valid;
`ifdef FETCH_HALT_EN
  assign bus.halt      = r_halt;
`else
  assign bus.halt      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk;
  logic rst;
  logic rst1;

  fetch_if #(.PC_WIDTH(8)) bus0 ();
  fetch_if #(.PC_WIDTH(8)) bus1 ();

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'hFE)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        ready;
    logic        ack;
    logic [15:0] rdata;
    logic        ben;
    logic [7:0]  tgt;
    logic        e_req;
    logic        e_valid;
    logic [15:0] e_ir;
    logic [7:0]  e_pc;
  } vec_t;

  function automatic vec_t v(input logic rdy, input logic ack, input logic [15:0] rd,
                             input logic ben, input logic [7:0] tgt, input logic e_req,
                             input logic e_val, input logic [15:0] e_ir, input logic [7:0] e_pc);
    vec_t r;
    r.ready = rdy; r.ack = ack; r.rdata = rd; r.ben = ben; r.tgt = tgt;
    r.e_req = e_req; r.e_valid = e_val; r.e_ir = e_ir; r.e_pc = e_pc;
    return r;
  endfunction

  function automatic logic [15:0] hmem(input logic [7:0] a);
    return (a == 8'd3) ? 16'hF000 : (16'h1000 + {8'h00, a});
  endfunction

  task automatic clr0();
    bus0.imem_ack = 1'b0; bus0.imem_rdata = '0; bus0.ir_ready = 1'b0;
    bus0.branch_en = 1'b0; bus0.branch_target = '0;
  endtask

  // Ends at a negedge with rst just released; the current cycle is IDLE.
  task automatic reset0();
    @(negedge clk);
    rst = 1'b1;
    clr0();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", bus0.pc, 8'h00);
    chk("rst_ir", bus0.ir_data, 16'h0000);
    chk("rst_req", bus0.imem_req, 1'b0);
    chk("rst_valid", bus0.ir_valid, 1'b0);
    chk("rst_halt", bus0.halt, 1'b0);
    rst = 1'b0;
  endtask

  vec_t vecs[24];
  logic [7:0] wrap_addr[4];
  int   n_wrap;
  bit   reached;

  initial begin
    rst = 1'b1;
    rst1 = 1'b1;
    clr0();
    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0; bus1.ir_ready = 1'b0;
    bus1.branch_en = 1'b0; bus1.branch_target = '0;

    //          rdy ack rdata    ben tgt    req val ir       pc
    vecs[0]  = v(0, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0000, 8'h00); // IDLE
    vecs[1]  = v(0, 1, 16'h1111, 0, 8'h00, 1, 0, 16'h0000, 8'h00); // req @0, zero-wait
    vecs[2]  = v(1, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h1111, 8'h00);
    vecs[3]  = v(0, 1, 16'h2222, 0, 8'h00, 1, 0, 16'h1111, 8'h01); // req @1
    vecs[4]  = v(1, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h2222, 8'h01);
    vecs[5]  = v(0, 1, 16'h3333, 0, 8'h00, 1, 0, 16'h2222, 8'h02); // req @2
    vecs[6]  = v(1, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h3333, 8'h02);
    vecs[7]  = v(0, 0, 16'h0000, 0, 8'h00, 1, 0, 16'h3333, 8'h03); // req @3, wait
    vecs[8]  = v(1, 0, 16'h0000, 1, 8'h55, 1, 0, 16'h3333, 8'h03); // branch in FETCH ignored
    vecs[9]  = v(0, 0, 16'h0000, 0, 8'h00, 1, 0, 16'h3333, 8'h03);
    vecs[10] = v(0, 1, 16'h0123, 0, 8'h00, 1, 0, 16'h3333, 8'h03); // ack 3 cycles later
    vecs[11] = v(0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0123, 8'h03);
    vecs[12] = v(0, 1, 16'hFFFF, 0, 8'h00, 0, 1, 16'h0123, 8'h03); // ack in HOLD ignored
    vecs[13] = v(0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0123, 8'h03);
    vecs[14] = v(0, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0123, 8'h03);
    vecs[15] = v(1, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h0123, 8'h03); // accept
    vecs[16] = v(0, 1, 16'h4444, 0, 8'h00, 1, 0, 16'h0123, 8'h04); // req @4
    vecs[17] = v(1, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h4444, 8'h04);
    vecs[18] = v(0, 1, 16'h5555, 0, 8'h00, 1, 0, 16'h4444, 8'h05); // req @5
    vecs[19] = v(1, 0, 16'h0000, 1, 8'h20, 0, 1, 16'h5555, 8'h05); // branch to 20
    vecs[20] = v(0, 1, 16'h6666, 0, 8'h00, 1, 0, 16'h5555, 8'h20); // req @20
    vecs[21] = v(0, 0, 16'h0000, 1, 8'h77, 0, 1, 16'h6666, 8'h20); // branch w/o ready ignored
    vecs[22] = v(1, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h6666, 8'h20);
    vecs[23] = v(0, 0, 16'h0000, 0, 8'h00, 1, 0, 16'h6666, 8'h21); // sequential @21

    // ---- table-driven: sequential, wait-state, branch ----
    reset0();
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("v%0d_req", i), bus0.imem_req, vecs[i].e_req);
      chk($sformatf("v%0d_valid", i), bus0.ir_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_ir", i), bus0.ir_data, vecs[i].e_ir);
      chk($sformatf("v%0d_pc", i), bus0.pc, vecs[i].e_pc);
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), bus0.imem_addr, vecs[i].e_pc);
      chk($sformatf("v%0d_halt", i), bus0.halt, 1'b0);
      bus0.ir_ready      = vecs[i].ready;
      bus0.imem_ack      = vecs[i].ack;
      bus0.imem_rdata    = vecs[i].rdata;
      bus0.branch_en     = vecs[i].ben;
      bus0.branch_target = vecs[i].tgt;
      @(negedge clk);
    end
    clr0();

    // ---- HALT word at address 3 ----
    reset0();
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      bus0.ir_ready = 1'b1;
      if (bus0.imem_req) begin
        bus0.imem_ack   = 1'b1;
        bus0.imem_rdata = hmem(bus0.imem_addr);
        reached = (bus0.imem_addr == 8'd3);
      end else begin
        bus0.imem_ack = 1'b0;
      end
      @(negedge clk);
    end
    chk("halt_reached", reached, 1'b1);
    clr0();
`ifdef FETCH_HALT_EN
    chk("halt_ir", bus0.ir_data, 16'hF000);
    for (int c = 0; c < 20; c++) begin
      chk("halt_flag", bus0.halt, 1'b1);
      chk("halt_valid", bus0.ir_valid, 1'b0);
      chk("halt_req", bus0.imem_req, 1'b0);
      chk("halt_pc", bus0.pc, 8'h03);
      bus0.ir_ready = 1'b1;
      bus0.imem_ack = 1'b1;
      @(negedge clk);
    end
    clr0();
`else
    chk("nohalt_valid", bus0.ir_valid, 1'b1);
    chk("nohalt_ir", bus0.ir_data, 16'hF000);
    chk("nohalt_flag", bus0.halt, 1'b0);
    bus0.ir_ready = 1'b1;
    @(negedge clk);
    bus0.ir_ready = 1'b0;
    chk("nohalt_req", bus0.imem_req, 1'b1);
    chk("nohalt_addr", bus0.imem_addr, 8'h04);
`endif

    // ---- reset while a request at PC=7 is being acked ----
    reset0();
    @(negedge clk);                         // IDLE -> FETCH
    bus0.imem_ack = 1'b1; bus0.imem_rdata = 16'h1234;
    @(negedge clk);                         // now HOLD
    bus0.imem_ack = 1'b0;
    bus0.ir_ready = 1'b1; bus0.branch_en = 1'b1; bus0.branch_target = 8'h07;
    @(negedge clk);
    clr0();
    chk("mid_req", bus0.imem_req, 1'b1);
    chk("mid_addr", bus0.imem_addr, 8'h07);
    rst = 1'b1;
    bus0.imem_ack = 1'b1; bus0.imem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("mid_ir", bus0.ir_data, 16'h0000);
    chk("mid_pc", bus0.pc, 8'h00);
    chk("mid_req_drop", bus0.imem_req, 1'b0);
    chk("mid_valid", bus0.ir_valid, 1'b0);
    rst = 1'b0;
    bus0.imem_ack = 1'b0;
    chk("mid_idle_req", bus0.imem_req, 1'b0);
    @(negedge clk);
    chk("mid_restart_req", bus0.imem_req, 1'b1);
    chk("mid_restart_addr", bus0.imem_addr, 8'h00);

    // ---- PC wrap on the RESET_PC=FE instance ----
    @(negedge clk);
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wrap_rst_pc", bus1.pc, 8'hFE);
    rst1 = 1'b0;
    n_wrap = 0;
    for (int c = 0; c < 30 && n_wrap < 4; c++) begin
      bus1.ir_ready = 1'b1;
      if (bus1.imem_req) begin
        bus1.imem_ack   = 1'b1;
        bus1.imem_rdata = 16'h0ABC;
        wrap_addr[n_wrap] = bus1.imem_addr;
        n_wrap++;
      end else begin
        bus1.imem_ack = 1'b0;
      end
      @(negedge clk);
    end
    bus1.imem_ack = 1'b0;
    chk("wrap_count", n_wrap, 4);
    if (n_wrap == 4) begin
      chk("wrap_a0", wrap_addr[0], 8'hFE);
      chk("wrap_a1", wrap_addr[1], 8'hFF);
      chk("wrap_a2", wrap_addr[2], 8'h00);
      chk("wrap_a3", wrap_addr[3], 8'h01);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
